// File: rtl/vga_sync_rx.sv
// VGA timing receiver: recovers active-window pixel coordinates from hsync/vsync,
// tracks timing lock and keeps a saturating count of timing errors.
module vga_sync_rx #(
  parameter int   H_TOTAL     = 800,
  parameter int   H_ACT_START = 144,
  parameter int   H_VALID     = 640,
  parameter int   V_TOTAL     = 525,
  parameter int   V_ACT_START = 35,
  parameter int   V_VALID     = 480,
  parameter logic SYNC_POL    = 1'b1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_cnt
);

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [9:0]  H_OFF   = 10'(H_ACT_START);
  localparam logic [9:0]  V_OFF   = 10'(V_ACT_START);
  localparam logic [10:0] H_LO    = 11'(H_ACT_START);
  localparam logic [10:0] H_HI    = 11'(H_ACT_START + H_VALID);
  localparam logic [10:0] V_LO    = 11'(V_ACT_START);
  localparam logic [10:0] V_HI    = 11'(V_ACT_START + V_VALID);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  lock_state_e state_r;

  logic        hs_r, vs_r, hs_prev_r, vs_prev_r;
  logic [15:0] rgb_r, rgb_d_r;
  logic [9:0]  h_cnt_r, line_r;
  logic        pend_r, hs_seen_r, vs_seen_r;

  logic        hs_lead_s, vs_lead_s;
  logic        line_err_s, frame_err_s, timeout_s, err_any_s, unlock_s;
  logic [9:0]  h_next_s, line_next_s;
  logic        h_win_s, v_win_s, win_valid_s;
  logic [9:0]  win_x_s, win_y_s;

  logic        valid_p_r, fs_p_r;
  logic [9:0]  x_p_r, y_p_r;
  logic [15:0] data_p_r;

  // Input capture plus one-sample history for edge detection.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_r      <= ~SYNC_POL;
      vs_r      <= ~SYNC_POL;
      hs_prev_r <= ~SYNC_POL;
      vs_prev_r <= ~SYNC_POL;
      rgb_r     <= 16'h0000;
    end else begin
      hs_r      <= hsync;
      vs_r      <= vsync;
      hs_prev_r <= hs_r;
      vs_prev_r <= vs_r;
      rgb_r     <= rgb;
    end
  end

  // Edge, position, error and active-window decode.
  always_comb begin
    hs_lead_s   = (hs_r == SYNC_POL) && (hs_prev_r != SYNC_POL);
    vs_lead_s   = (vs_r == SYNC_POL) && (vs_prev_r != SYNC_POL);
    line_err_s  = hs_lead_s && hs_seen_r && (h_cnt_r != H_LAST);
    frame_err_s = vs_lead_s && vs_seen_r && (line_r != V_LAST);

    // Timeout fires only on the step into saturation, never while parked there.
    if (hs_lead_s) begin
      h_next_s  = 10'd0;
      timeout_s = 1'b0;
    end else if (h_cnt_r == CNT_MAX) begin
      h_next_s  = CNT_MAX;
      timeout_s = 1'b0;
    end else begin
      h_next_s  = h_cnt_r + 10'd1;
      timeout_s = (h_cnt_r == (CNT_MAX - 10'd1));
    end

    if (hs_lead_s && (pend_r || vs_lead_s)) begin
      line_next_s = 10'd0;
    end else if (hs_lead_s && (line_r != CNT_MAX)) begin
      line_next_s = line_r + 10'd1;
    end else begin
      line_next_s = line_r;
    end

    err_any_s = line_err_s | frame_err_s | timeout_s;
    unlock_s  = err_any_s && (state_r != UNLOCKED);

    h_win_s     = ({1'b0, h_cnt_r} >= H_LO) && ({1'b0, h_cnt_r} < H_HI);
    v_win_s     = ({1'b0, line_r} >= V_LO) && ({1'b0, line_r} < V_HI);
    win_valid_s = locked && h_win_s && v_win_s;
    if (win_valid_s) begin
      win_x_s = h_cnt_r - H_OFF;
      win_y_s = line_r - V_OFF;
    end else begin
      win_x_s = 10'd0;
      win_y_s = 10'd0;
    end
  end

  // Horizontal/line counters, pending-frame flag and saturating error count.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt_r <= 10'd0;
      line_r  <= 10'd0;
      pend_r  <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      h_cnt_r <= h_next_s;
      line_r  <= line_next_s;
      if (hs_lead_s) begin
        pend_r <= 1'b0;
      end else if (vs_lead_s) begin
        pend_r <= 1'b1;
      end else begin
        pend_r <= pend_r;
      end
      if (err_any_s && (err_cnt != 8'd255)) begin
        err_cnt <= err_cnt + 8'd1;
      end else begin
        err_cnt <= err_cnt;
      end
    end
  end

  // Lock FSM; the seen flags grant the first edge after reset/unlock an exemption.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= UNLOCKED;
      locked    <= 1'b0;
      hs_seen_r <= 1'b0;
      vs_seen_r <= 1'b0;
    end else begin
      case (state_r)
        UNLOCKED: begin
          if (vs_lead_s && !err_any_s) begin
            state_r <= ACQUIRE;
          end else begin
            state_r <= UNLOCKED;
          end
          locked <= 1'b0;
        end
        ACQUIRE: begin
          if (err_any_s) begin
            state_r <= UNLOCKED;
            locked  <= 1'b0;
          end else if (vs_lead_s) begin
            state_r <= LOCKED;
            locked  <= 1'b1;
          end else begin
            state_r <= ACQUIRE;
            locked  <= 1'b0;
          end
        end
        LOCKED: begin
          if (err_any_s) begin
            state_r <= UNLOCKED;
            locked  <= 1'b0;
          end else begin
            state_r <= LOCKED;
            locked  <= 1'b1;
          end
        end
        default: begin
          state_r <= UNLOCKED;
          locked  <= 1'b0;
        end
      endcase
      if (unlock_s) begin
        hs_seen_r <= 1'b0;
        vs_seen_r <= 1'b0;
      end else begin
        hs_seen_r <= hs_seen_r | hs_lead_s;
        vs_seen_r <= vs_seen_r | vs_lead_s;
      end
    end
  end

  // Output pipeline: the window decode is staged once more to land 3 cycles after sampling.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rgb_d_r     <= 16'h0000;
      valid_p_r   <= 1'b0;
      fs_p_r      <= 1'b0;
      x_p_r       <= 10'd0;
      y_p_r       <= 10'd0;
      data_p_r    <= 16'h0000;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_data    <= 16'h0000;
    end else begin
      rgb_d_r     <= rgb_r;
      valid_p_r   <= win_valid_s;
      fs_p_r      <= win_valid_s && (win_x_s == 10'd0) && (win_y_s == 10'd0);
      x_p_r       <= win_x_s;
      y_p_r       <= win_y_s;
      data_p_r    <= win_valid_s ? rgb_d_r : 16'h0000;
      pix_valid   <= valid_p_r;
      frame_start <= fs_p_r;
      pix_x       <= x_p_r;
      pix_y       <= y_p_r;
      pix_data    <= data_p_r;
    end
  end

endmodule
